// File: rtl/word_bram_adapter.sv
// Word-to-byte adapter: splits each client word read/write into WORD_BYTES byte beats on a byte-wide single-port BRAM.
// Latency: write completes (wr_done) N+1 cycles after accept; read completes (rsp_valid) N+BRAM_LATENCY+1 cycles after accept.
// Backpressure: req_ready is high only in IDLE; one transaction in flight, request inputs ignored while busy.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (accept on req_valid && req_ready)
//   req_write, req_flip, req_addr,
//   req_wdata                         request fields, sampled at accept
//   rsp_valid, rsp_rdata              read completion pulse and word (held until next read completes)
//   wr_done                           write completion pulse
//   addr_wrap                         pulses with completion when any beat address wrapped
//   busy                              high whenever not IDLE
//   bram_we, bram_addr, bram_din,
//   bram_dout                         byte-wide BRAM port
module word_bram_adapter #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORD_BYTES   = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int BRAM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic                             req_flip,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] req_wdata,
  output logic                             rsp_valid,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] rsp_rdata,
  output logic                             wr_done,
  output logic                             addr_wrap,
  output logic                             busy,
  output logic                             bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_din,
  input  logic [DATA_WIDTH-1:0]            bram_dout
);

  localparam int WW = WORD_BYTES * DATA_WIDTH;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [BW-1:0] r_beat;
  logic          r_flip;
  logic          r_wrap;
  logic [WW-1:0] r_wdata;
  logic [WW-1:0] r_acc;
  logic [WW-1:0] w_acc_nxt;

  // Read capture pipeline: one stage per cycle of BRAM latency, carrying
  // the destination lane and a last-beat marker alongside each issued beat.
  logic [BRAM_LATENCY-1:0]         r_pv;
  logic [BRAM_LATENCY-1:0]         r_plast;
  logic [BRAM_LATENCY-1:0][BW-1:0] r_plane;

  logic              w_accept;
  logic              w_last_beat;
  logic [BW-1:0]     w_beat_nxt;
  logic              w_cap;
  logic              w_cap_last;
  logic [BW-1:0]     w_cap_lane;
  logic [ADDR_WIDTH:0] w_req_end;
  logic              w_req_wrap;

  function automatic logic [BW-1:0] lane_of(input logic [BW-1:0] beat, input logic flip);
    return flip ? (LAST - beat) : beat;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] get_lane(input logic [WW-1:0] word, input logic [BW-1:0] idx);
    return word[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_last_beat = (r_beat == LAST);
  assign w_beat_nxt  = r_beat + 1'b1;
  assign w_cap       = r_pv[BRAM_LATENCY-1];
  assign w_cap_last  = w_cap && r_plast[BRAM_LATENCY-1];
  assign w_cap_lane  = r_plane[BRAM_LATENCY-1];

  // The last beat address overflows the address space exactly when
  // base + N - 1 carries out of ADDR_WIDTH bits.
  assign w_req_end  = {1'b0, req_addr} + (ADDR_WIDTH+1)'(WORD_BYTES - 1);
  assign w_req_wrap = w_req_end[ADDR_WIDTH];

  always_comb begin
    w_acc_nxt = r_acc;
    if (w_cap) begin
      w_acc_nxt[w_cap_lane*DATA_WIDTH +: DATA_WIDTH] = bram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = req_write ? WR_BEAT : RD_ISSUE;
      WR_BEAT:  if (w_last_beat) w_state_nxt = IDLE;
      RD_ISSUE: if (w_last_beat) w_state_nxt = RD_DRAIN;
      RD_DRAIN: if (w_cap_last) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_flip    <= 1'b0;
      r_wrap    <= 1'b0;
      r_wdata   <= '0;
      r_acc     <= '0;
      r_pv      <= '0;
      r_plast   <= '0;
      r_plane   <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
      addr_wrap <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      addr_wrap <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_beat    <= '0;
            r_flip    <= req_flip;
            r_wrap    <= w_req_wrap;
            r_wdata   <= req_wdata;
            bram_addr <= req_addr;
            bram_we   <= req_write;
            if (req_write) begin
              bram_din <= get_lane(req_wdata, lane_of('0, req_flip));
            end
          end
        end
        WR_BEAT: begin
          if (w_last_beat) begin
            bram_we   <= 1'b0;
            wr_done   <= 1'b1;
            addr_wrap <= r_wrap;
          end else begin
            r_beat    <= w_beat_nxt;
            bram_addr <= bram_addr + 1'b1;
            bram_din  <= get_lane(r_wdata, lane_of(w_beat_nxt, r_flip));
          end
        end
        RD_ISSUE: begin
          if (!w_last_beat) begin
            r_beat    <= w_beat_nxt;
            bram_addr <= bram_addr + 1'b1;
          end
        end
        default: ;
      endcase

      // Stage 0 is loaded at the end of the cycle in which the beat address
      // is on the bus, so the last stage lines up with bram_dout.
      for (int k = BRAM_LATENCY - 1; k > 0; k--) begin
        r_pv[k]    <= r_pv[k-1];
        r_plast[k] <= r_plast[k-1];
        r_plane[k] <= r_plane[k-1];
      end
      r_pv[0]    <= (r_state == RD_ISSUE);
      r_plast[0] <= (r_state == RD_ISSUE) && w_last_beat;
      r_plane[0] <= lane_of(r_beat, r_flip);

      r_acc <= w_acc_nxt;
      // Publish the whole word only once the final lane lands.
      if (w_cap_last) begin
        rsp_rdata <= w_acc_nxt;
        rsp_valid <= 1'b1;
        addr_wrap <= r_wrap;
      end
    end
  end

endmodule

// File: tb/tb_word_bram_adapter.sv
// Testbench for word_bram_adapter: scoreboard against a byte-array memory model.
// Main instance N=2, LAT=1 (directed + random); second instance N=4, LAT=3 (directed reads).
// Completion pulses, BRAM write beats and timing are checked by monitors decoupled from stimulus.
module tb_word_bram_adapter;

  localparam int N   = 2;
  localparam int LAT = 1;
  localparam int WW  = N * 8;
  localparam int N4   = 4;
  localparam int LAT4 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- main DUT ----------------
  logic          req_valid, req_ready, req_write, req_flip;
  logic [7:0]    req_addr;
  logic [WW-1:0] req_wdata;
  logic          rsp_valid, wr_done, addr_wrap, busy, bram_we;
  logic [WW-1:0] rsp_rdata;
  logic [7:0]    bram_addr, bram_din, bram_dout;

  word_bram_adapter #(.DATA_WIDTH(8), .WORD_BYTES(N), .ADDR_WIDTH(8), .BRAM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_flip(req_flip),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done), .addr_wrap(addr_wrap),
    .busy(busy), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [7:0] bmem [256];
  logic [7:0] brd  [LAT];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) bmem[i] <= 8'h00;
    end else begin
      if (bram_we) bmem[bram_addr] <= bram_din;
      brd[0] <= bmem[bram_addr];
      for (int k = 1; k < LAT; k++) brd[k] <= brd[k-1];
    end
  end
  assign bram_dout = brd[LAT-1];

  // ---------------- N=4, LAT=3 DUT ----------------
  logic          u_req_valid, u_req_ready, u_req_write, u_req_flip;
  logic [7:0]    u_req_addr;
  logic [31:0]   u_req_wdata, u_rsp_rdata;
  logic          u_rsp_valid, u_wr_done, u_addr_wrap, u_busy, u_bram_we;
  logic [7:0]    u_bram_addr, u_bram_din, u_bram_dout;

  word_bram_adapter #(.DATA_WIDTH(8), .WORD_BYTES(N4), .ADDR_WIDTH(8), .BRAM_LATENCY(LAT4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(u_req_valid), .req_ready(u_req_ready), .req_write(u_req_write), .req_flip(u_req_flip),
    .req_addr(u_req_addr), .req_wdata(u_req_wdata),
    .rsp_valid(u_rsp_valid), .rsp_rdata(u_rsp_rdata), .wr_done(u_wr_done), .addr_wrap(u_addr_wrap),
    .busy(u_busy), .bram_we(u_bram_we), .bram_addr(u_bram_addr), .bram_din(u_bram_din), .bram_dout(u_bram_dout)
  );

  logic [7:0] bmem4 [256];
  logic [7:0] brd4  [LAT4];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) bmem4[i] <= 8'h00;
      bmem4[8'h20] <= 8'h11;
      bmem4[8'h21] <= 8'h22;
      bmem4[8'h22] <= 8'h33;
      bmem4[8'h23] <= 8'h44;
    end else begin
      if (u_bram_we) bmem4[u_bram_addr] <= u_bram_din;
      brd4[0] <= bmem4[u_bram_addr];
      for (int k = 1; k < LAT4; k++) brd4[k] <= brd4[k-1];
    end
  end
  assign u_bram_dout = brd4[LAT4-1];

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { bit wr; bit [WW-1:0] data; bit wrap; int t; } rsp_t;
  typedef struct { int t; bit [7:0] a; bit [7:0] d; } beat_t;
  rsp_t  rsp_q[$];
  beat_t beat_q[$];
  bit [7:0] ref_mem [256];
  int last_wrdone_cyc = -1;

  rsp_t  req_e;
  beat_t req_b;
  bit [7:0] req_a;
  int    req_lane;

  // Request side: on every handshake compute the expected outcome from the
  // byte-array model: beat i touches (addr+i) mod 256 and maps to lane i or N-1-i.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      req_e.wr   = req_write;
      req_e.t    = cyc;
      req_e.wrap = (int'(req_addr) + N - 1) > 255;
      req_e.data = '0;
      for (int i = 0; i < N; i++) begin
        req_a    = req_addr + 8'(i);
        req_lane = req_flip ? (N - 1 - i) : i;
        if (req_write) begin
          ref_mem[req_a] = req_wdata[req_lane*8 +: 8];
          req_b.t = cyc + 1 + i;
          req_b.a = req_a;
          req_b.d = req_wdata[req_lane*8 +: 8];
          beat_q.push_back(req_b);
        end else begin
          req_e.data[req_lane*8 +: 8] = ref_mem[req_a];
        end
      end
      rsp_q.push_back(req_e);
    end
  end

  rsp_t  mon_e;
  beat_t mon_b;

  // Response side: pop and compare whenever the DUT signals something.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", req_ready, !busy);
      if (rsp_valid || wr_done) begin
        if (rsp_q.size() == 0) begin
          flag("unexpected_completion");
        end else begin
          mon_e = rsp_q.pop_front();
          chk("completion_kind", {rsp_valid, wr_done}, mon_e.wr ? 2'b01 : 2'b10);
          chk("completion_latency", cyc - mon_e.t, mon_e.wr ? (N + 1) : (N + LAT + 1));
          chk("addr_wrap", addr_wrap, mon_e.wrap);
          if (!mon_e.wr) chk("rsp_rdata", rsp_rdata, mon_e.data);
          else last_wrdone_cyc = cyc;
        end
      end else if (addr_wrap) begin
        flag("addr_wrap_without_completion");
      end
      if (bram_we) begin
        if (beat_q.size() == 0) begin
          flag("unexpected_bram_write");
        end else begin
          mon_b = beat_q.pop_front();
          chk("wbeat_cycle", cyc, mon_b.t);
          chk("wbeat_addr", bram_addr, mon_b.a);
          chk("wbeat_data", bram_din, mon_b.d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit w, input bit f, input logic [7:0] a, input logic [WW-1:0] d);
    bit ok;
    req_write = w; req_flip = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) flag("accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && beat_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) flag("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bram_we"}, bram_we, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_bram_din"}, bram_din, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_addr_wrap"}, addr_wrap, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic u4_read(input bit f, input logic [31:0] exp);
    int t0;
    u_req_write = 1'b0; u_req_flip = f; u_req_addr = 8'h20; u_req_valid = 1'b1;
    @(negedge clk);
    chk("u4_ready_idle", u_req_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    u_req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("u4_rsp_valid_timing", u_rsp_valid, (k == N4 + LAT4 + 1));
      if (k < N4 + LAT4 + 1) chk("u4_ready_low", u_req_ready, 0);
      if (k == N4 + LAT4 + 1) begin
        chk("u4_rsp_rdata", u_rsp_rdata, exp);
        chk("u4_addr_wrap", u_addr_wrap, 0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 0; req_write = 0; req_flip = 0; req_addr = 0; req_wdata = 0;
    u_req_valid = 0; u_req_write = 0; u_req_flip = 0; u_req_addr = 0; u_req_wdata = 0;
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    chk("u4_reset_ready", u_req_ready, 1);
    chk("u4_reset_rdata", u_rsp_rdata, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: basic write/read, flip, wrap.
    send(1'b1, 1'b0, 8'h10, 16'hBEEF); wait_idle();
    send(1'b0, 1'b0, 8'h10, 16'h0000); wait_idle();
    send(1'b0, 1'b1, 8'h10, 16'h0000); wait_idle();
    send(1'b1, 1'b0, 8'hFF, 16'h1234); wait_idle();
    send(1'b0, 1'b0, 8'hFF, 16'h0000); wait_idle();

    // Back-to-back: request held valid across the write; read must be
    // accepted in the wr_done cycle.
    req_write = 1'b1; req_flip = 1'b0; req_addr = 8'h40; req_wdata = 16'hA5A5; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_write = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) flag("b2b_accept_timeout");
      chk("b2b_accept_in_wr_done_cycle", wr_done, 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // Reset during a read: no completion may ever appear.
    req_write = 1'b0; req_flip = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    rsp_q.delete();
    beat_q.delete();
    #1 check_reset("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(1'b0, 1'b0, 8'h10, 16'h0000); wait_idle();

    // Random traffic, biased towards the wrap boundary, with random gaps
    // and frequent requests queued while the adapter is still busy.
    for (int it = 0; it < 150; it++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, WW'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    // Wider word, longer latency.
    u4_read(1'b0, 32'h44332211);
    u4_read(1'b1, 32'h11223344);

    chk("scoreboard_drained", rsp_q.size() + beat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
